bcd_alu_sequencer: RTL and testbench
====================================

BCD_ALU_SEQUENCER -- requirements
Module: bcd_alu_sequencer

Interface
REQ-001 SHALL have no parameters; operand width fixed at 16 bits, nibble-serial.
REQ-002 SHALL have port CLK  in  1  single clock, all state rising-edge.
REQ-003 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port EN  in  1  clock enable; EN=0 freezes all state.
REQ-005 SHALL have port START  in  1  launch request, sampled in IDLE with EN=1.
REQ-006 SHALL have ports A, B  in  16 each  operands.
REQ-007 SHALL have port CI  in  1  carry-in; SBC uses CI=1 for no borrow.
REQ-008 SHALL have port ADD  in  1  1=ADC, 0=SBC.
REQ-009 SHALL have port BCD  in  1  1=decimal mode.
REQ-010 SHALL have port W16  in  1  1=16-bit op (4 nibbles), 0=8-bit op (2 nibbles).
REQ-011 SHALL have port BUSY  out  1  high in CALC state.
REQ-012 SHALL have port DONE  out  1  one-cycle completion pulse.
REQ-013 SHALL have ports S  out  16  result; CO, VO, ZO, NO  out  1 each  carry, overflow, zero, negative.

Function
REQ-014 SHALL implement FSM IDLE -> CALC -> FIN -> IDLE; all transitions occur only when EN=1.
REQ-015 IDLE with START=1: SHALL latch A, B, CI, ADD, BCD, W16; clear nibble index to 0; go to CALC.
REQ-016 CALC: each cycle SHALL process nibble[idx] through one shared nibble adder, with carry-in from the carry register (CI for idx 0); write the sum nibble to S[4*idx+3:4*idx]; update the carry register; increment idx.
REQ-017 CALC SHALL exit to FIN after idx 1 (W16=0) or idx 3 (W16=1); the last nibble SHALL also set CO and VO.
REQ-018 FIN: DONE=1 for exactly one cycle, then IDLE; latency START(t) -> DONE(t+N+1), N = 2 or 4.
REQ-019 CO SHALL be the final nibble carry, already inverted to borrow sense for SBC.
REQ-020 VO SHALL equal the nibble-adder overflow of the top nibble of the active width.
REQ-021 W16=0: S[15:8] SHALL be latched A[15:8] unchanged; ZO/NO SHALL be computed on S[7:0] and bit 7.
REQ-022 W16=1: ZO/NO SHALL be computed on S[15:0] and bit 15.
REQ-023 S and the flags SHALL hold their values from FIN until the next launch; mid-operation values are undefined to the consumer.
REQ-024 START while BUSY or in FIN SHALL be ignored; there is no queueing.
REQ-025 Operand changes after launch SHALL NOT affect the result.
REQ-026 Nibble-adder arithmetic: B is inverted when ADD=0; decimal correction is +6 on ADD or -6 on SBC when BCD=1.

Reset
REQ-027 RST=1 SHALL force state IDLE asynchronously, regardless of EN.
REQ-028 RST=1 SHALL clear S=0, CO=VO=NO=0, ZO=1, BUSY=0, DONE=0, idx=0, and the carry register.
REQ-029 RST mid-operation SHALL abort with no DONE; the first START after release SHALL behave as from power-up.

Configuration
REQ-030 With macro BCD_SEQ_DECIMAL_EN defined, SHALL support decimal mode per REQ-026.
REQ-031 Without BCD_SEQ_DECIMAL_EN, SHALL treat BCD as 0 (pure binary), remove the correction logic, and leave all other timing identical.

Structure
REQ-032 Package bcd_seq_pkg SHALL hold the FSM state enum (IDLE, CALC, FIN) and constants NIB8=2 and NIB16=4.
REQ-033 SHALL instantiate exactly one sub-module, bcd_nibble_add: a combinational 4-bit add/sub with decimal correction, reused every CALC cycle.

Verification
REQ-034 8-bit BCD ADC, A=0x0045, B=0x0038, CI=0 -> S=0x0083, CO=0, NO=1, DONE at t+3.
REQ-035 16-bit BCD ADC, 0x9999 + 0x0001, CI=0 -> S=0x0000, CO=1, ZO=1, DONE at t+5, BUSY high for 4 cycles.
REQ-036 8-bit binary ADC, 0x7F + 0x01, CI=0 -> S[7:0]=0x80, VO=1, NO=1, CO=0; A[15:8]=0x12 -> S[15:8]=0x12.
REQ-037 16-bit BCD SBC, 0x0000 - 0x0001, CI=1 -> S=0x9999, CO=0; binary 8-bit SBC, 0x50 - 0x70, CI=1 -> 0xE0, CO=0, VO=0, NO=1.
REQ-038 Control corners: RST pulse during CALC idx 2 -> IDLE, no DONE, reset values; START reasserted during BUSY -> ignored, single DONE; EN=0 for 3 cycles mid-CALC -> DONE delayed by exactly 3.

Source files
------------

// File: rtl/bcd_seq_pkg.sv
// bcd_seq_pkg: shared types for the nibble-serial BCD/binary ALU.
// Holds the sequencer state enum and the nibble counts per width.
package bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  localparam int NIB8  = 2;
  localparam int NIB16 = 4;

endpackage

// File: rtl/bcd_nibble_add.sv
// bcd_nibble_add: combinational 4-bit add/sub with decimal correction.
// Ports: i_a/i_b nibbles, i_cin carry-in, i_add (1=ADC, 0=SBC),
//   i_bcd decimal mode; o_sum, o_cout (1 = no borrow on SBC),
//   o_ovf signed nibble overflow of the uncorrected sum.
// Decimal correction exists only with BCD_SEQ_DECIMAL_EN defined.
module bcd_nibble_add (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  input  logic       i_add,
  input  logic       i_bcd,
  output logic [3:0] o_sum,
  output logic       o_cout,
  output logic       o_ovf
);

  logic [3:0] w_b;
  logic [4:0] w_bin;

  assign w_b   = i_add ? i_b : ~i_b;
  assign w_bin = {1'b0, i_a} + {1'b0, w_b} + {4'b0, i_cin};
  assign o_ovf = (i_a[3] == w_b[3]) && (w_bin[3] != i_a[3]);

`ifdef BCD_SEQ_DECIMAL_EN
  // Decimal carry: ADC carries past 9; SBC keeps the raw carry,
  // and a borrow (carry 0) pulls the digit back by 6.
  logic w_dc;

  assign w_dc = i_add ? (w_bin > 5'd9) : w_bin[4];

  always_comb begin
    o_sum  = w_bin[3:0];
    o_cout = w_bin[4];
    if (i_bcd) begin
      o_cout = w_dc;
      if (i_add && w_dc)
        o_sum = w_bin[3:0] + 4'd6;
      else if (!i_add && !w_dc)
        o_sum = w_bin[3:0] - 4'd6;
    end
  end
`else
  logic w_unused_bcd;

  assign w_unused_bcd = i_bcd;
  assign o_sum        = w_bin[3:0];
  assign o_cout       = w_bin[4];
`endif

endmodule

// File: rtl/bcd_alu_sequencer.sv
// bcd_alu_sequencer: nibble-serial 8/16-bit ADC/SBC, binary or BCD.
// Ports: CLK, RST (async high), EN clock enable, START launch,
//   A/B operands, CI carry-in, ADD (1=ADC), BCD decimal, W16 width;
//   BUSY (CALC), DONE (FIN pulse), S result, CO/VO/ZO/NO flags.
// Decimal mode needs BCD_SEQ_DECIMAL_EN; otherwise BCD is ignored.
module bcd_alu_sequencer
  import bcd_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        START,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        CI,
  input  logic        ADD,
  input  logic        BCD,
  input  logic        W16,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] S,
  output logic        CO,
  output logic        VO,
  output logic        ZO,
  output logic        NO
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_s;
  logic [15:0] r_b;
  logic [15:0] w_s_nxt;
  logic [1:0]  r_idx;
  logic        r_c;
  logic        r_add;
  logic        r_w16;
  logic        r_co;
  logic        r_vo;
  logic        r_zo;
  logic        r_no;
  logic        w_bcd;
  logic        w_launch;
  logic        w_step;
  logic        w_last;
  logic [3:0]  w_sh;
  logic [3:0]  w_a_nib;
  logic [3:0]  w_b_nib;
  logic [3:0]  w_sum;
  logic        w_cout;
  logic        w_ovf;

`ifdef BCD_SEQ_DECIMAL_EN
  logic r_bcd;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_bcd <= 1'b0;
    else if (w_launch)
      r_bcd <= BCD;
  end

  assign w_bcd = r_bcd;
`else
  logic w_unused_bcd;

  assign w_unused_bcd = BCD;
  assign w_bcd        = 1'b0;
`endif

  // r_s doubles as the A operand: each nibble is read, then
  // overwritten by its sum, so the untouched upper byte of an
  // 8-bit op is simply the latched A[15:8].
  assign w_sh    = {r_idx, 2'b00};
  assign w_a_nib = r_s[w_sh +: 4];
  assign w_b_nib = r_b[w_sh +: 4];
  assign w_last  = r_w16 ? (r_idx == 2'(NIB16 - 1))
                         : (r_idx == 2'(NIB8 - 1));

  bcd_nibble_add u_nib (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_c),
    .i_add  (r_add),
    .i_bcd  (w_bcd),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_ovf  (w_ovf)
  );

  always_comb begin
    w_s_nxt             = r_s;
    w_s_nxt[w_sh +: 4]  = w_sum;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_step      = 1'b0;
    BUSY        = 1'b0;
    DONE        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (EN && START) begin
          w_launch    = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        BUSY = 1'b1;
        if (EN) begin
          w_step = 1'b1;
          if (w_last)
            w_state_nxt = FIN;
        end
      end
      FIN: begin
        DONE = 1'b1;
        if (EN)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s   <= '0;
      r_b   <= '0;
      r_idx <= '0;
      r_c   <= 1'b0;
      r_add <= 1'b0;
      r_w16 <= 1'b0;
      r_co  <= 1'b0;
      r_vo  <= 1'b0;
      r_zo  <= 1'b1;
      r_no  <= 1'b0;
    end else if (w_launch) begin
      r_s   <= A;
      r_b   <= B;
      r_c   <= CI;
      r_add <= ADD;
      r_w16 <= W16;
      r_idx <= '0;
    end else if (w_step) begin
      r_s   <= w_s_nxt;
      r_c   <= w_cout;
      r_idx <= r_idx + 2'd1;
      if (w_last) begin
        r_co <= w_cout;
        r_vo <= w_ovf;
        r_zo <= r_w16 ? (w_s_nxt == 16'h0000)
                      : (w_s_nxt[7:0] == 8'h00);
        r_no <= r_w16 ? w_s_nxt[15] : w_s_nxt[7];
      end
    end
  end

  assign S  = r_s;
  assign CO = r_co;
  assign VO = r_vo;
  assign ZO = r_zo;
  assign NO = r_no;

endmodule

// File: tb/tb_bcd_alu_sequencer.sv
// tb_bcd_alu_sequencer: directed vectors, per-cycle model compare.
// Model computes results from decimal/integer arithmetic.
module tb_bcd_alu_sequencer;

`ifdef BCD_SEQ_DECIMAL_EN
  localparam bit DEC_EN = 1'b1;
  localparam logic [15:0] E34_S = 16'h0083;
  localparam logic E34_NO = 1'b1;
  localparam logic [15:0] E35_S = 16'h0000;
  localparam logic E35_CO = 1'b1;
  localparam logic E35_ZO = 1'b1;
  localparam logic [15:0] E37_S = 16'h9999;
`else
  localparam bit DEC_EN = 1'b0;
  localparam logic [15:0] E34_S = 16'h007D;
  localparam logic E34_NO = 1'b0;
  localparam logic [15:0] E35_S = 16'h999A;
  localparam logic E35_CO = 1'b0;
  localparam logic E35_ZO = 1'b0;
  localparam logic [15:0] E37_S = 16'hFFFF;
`endif

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        vo;
    logic        zo;
    logic        no;
    logic        vchk;
  } res_t;

  logic        CLK;
  logic        RST;
  logic        EN;
  logic        START;
  logic [15:0] A;
  logic [15:0] B;
  logic        CI;
  logic        ADD;
  logic        BCD;
  logic        W16;
  logic        BUSY;
  logic        DONE;
  logic [15:0] S;
  logic        CO;
  logic        VO;
  logic        ZO;
  logic        NO;

  int n_chk = 0;
  int n_err = 0;
  int n_busy = 0;

  bcd_alu_sequencer dut (
    .CLK(CLK), .RST(RST), .EN(EN), .START(START),
    .A(A), .B(B), .CI(CI), .ADD(ADD), .BCD(BCD),
    .W16(W16), .BUSY(BUSY), .DONE(DONE), .S(S),
    .CO(CO), .VO(VO), .ZO(ZO), .NO(NO)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int dec(input logic [15:0] v, input int n);
    int r;
    int p;
    r = 0;
    p = 1;
    for (int i = 0; i < n; i++) begin
      r = r + int'(v[4*i +: 4]) * p;
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] enc(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic res_t calc(input logic [15:0] a,
                                input logic [15:0] b,
                                input logic ci, ad, bc, w);
    res_t r;
    int n, md, ia, ib, t, sa, sb;
    logic [15:0] lo;
    r = '0;
    n = w ? 4 : 2;
    md = 1 << (4 * n);
    if (bc) begin
      md = w ? 10000 : 100;
      ia = dec(a, n);
      ib = dec(b, n);
      t = ad ? ia + ib + int'(ci) : ia - ib - 1 + int'(ci);
      r.co = ad ? (t >= md) : (t >= 0);
      t = (t + md) % md;
      lo = enc(t);
      r.vchk = 1'b0;
    end else begin
      ia = int'(a) % md;
      ib = ad ? int'(b) % md : (md - 1) - int'(b) % md;
      t = ia + ib + int'(ci);
      r.co = (t >= md);
      lo = 16'(t % md);
      sa = (ia >= md / 2) ? ia - md : ia;
      sb = (ib >= md / 2) ? ib - md : ib;
      t = sa + sb + int'(ci);
      r.vo = (t >= md / 2) || (t < -(md / 2));
      r.vchk = 1'b1;
    end
    r.s = w ? lo : {a[15:8], lo[7:0]};
    r.zo = w ? (lo == 16'h0) : (lo[7:0] == 8'h0);
    r.no = w ? lo[15] : lo[7];
    return r;
  endfunction

  // Model: an op occupies N enabled cycles, then one done cycle.
  int   m_left;
  logic m_fin;
  res_t m_res;
  res_t p_res;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_left <= 0;
      m_fin  <= 1'b0;
      m_res  <= '{s: 16'h0, co: 1'b0, vo: 1'b0,
                  zo: 1'b1, no: 1'b0, vchk: 1'b1};
    end else if (EN) begin
      if (m_fin) begin
        m_fin <= 1'b0;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_fin <= 1'b1;
          m_res <= p_res;
        end
      end else if (START) begin
        p_res  <= calc(A, B, CI, ADD, BCD & DEC_EN, W16);
        m_left <= W16 ? 4 : 2;
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      chk("busy", 32'(BUSY), 32'(m_left > 0));
      chk("done", 32'(DONE), 32'(m_fin));
      if (m_left == 0) begin
        chk("s", 32'(S), 32'(m_res.s));
        chk("co", 32'(CO), 32'(m_res.co));
        chk("zo", 32'(ZO), 32'(m_res.zo));
        chk("no", 32'(NO), 32'(m_res.no));
        if (m_res.vchk)
          chk("vo", 32'(VO), 32'(m_res.vo));
      end
    end
  end

  task automatic launch(input logic [15:0] a, b,
                        input logic ci, ad, bc, w);
    @(posedge CLK); #1;
    A = a; B = b; CI = ci; ADD = ad; BCD = bc; W16 = w;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    A = 16'($urandom);
    B = 16'($urandom);
    CI = ~ci; ADD = ~ad; BCD = ~bc; W16 = ~w;
  endtask

  // Called one step after an edge in cycle c0; returns at the
  // negedge of the DONE cycle (or after the bound expires).
  task automatic wait_done(input int exp_lat, input int c0,
                           input string nm);
    int c;
    bit got;
    c = c0;
    got = 1'b0;
    n_busy = 0;
    while (!got && c < 40) begin
      @(negedge CLK);
      if (DONE) got = 1'b1;
      else begin
        if (BUSY) n_busy++;
        c++;
        @(posedge CLK); #1;
      end
    end
    chk(nm, 32'(c), 32'(exp_lat));
  endtask

  task automatic pin(input string nm, input res_t r,
                     input logic [15:0] s, input logic co,
                     input logic zo, input logic no);
    chk({nm, "_ms"}, 32'(r.s), 32'(s));
    chk({nm, "_mco"}, 32'(r.co), 32'(co));
    chk({nm, "_mzo"}, 32'(r.zo), 32'(zo));
    chk({nm, "_mno"}, 32'(r.no), 32'(no));
  endtask

  logic [15:0] xa [4] = '{16'h8000, 16'h1234, 16'h0042, 16'h00FF};
  logic [15:0] xb [4] = '{16'h8000, 16'h1234, 16'h0017, 16'h0001};
  logic        xad[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic        xbc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic        xw [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int cnt;
    res_t r;
    RST = 1'b1; EN = 1'b1; START = 1'b0;
    A = '0; B = '0; CI = 1'b0; ADD = 1'b1; BCD = 1'b0; W16 = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    chk("rst_s", 32'(S), 32'h0);
    chk("rst_zo", 32'(ZO), 32'h1);
    chk("rst_co", 32'(CO), 32'h0);
    chk("rst_vo", 32'(VO), 32'h0);
    chk("rst_no", 32'(NO), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_done", 32'(DONE), 32'h0);
    RST = 1'b0;

    r = calc(16'h0045, 16'h0038, 1'b0, 1'b1, DEC_EN, 1'b0);
    pin("m34", r, E34_S, 1'b0, 1'b0, E34_NO);
    launch(16'h0045, 16'h0038, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_done(3, 1, "lat34");
    chk("t34_s", 32'(S), 32'(E34_S));
    chk("t34_co", 32'(CO), 32'h0);
    chk("t34_no", 32'(NO), 32'(E34_NO));

    r = calc(16'h9999, 16'h0001, 1'b0, 1'b1, DEC_EN, 1'b1);
    pin("m35", r, E35_S, E35_CO, E35_ZO, 1'b1 ^ DEC_EN);
    launch(16'h9999, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_done(5, 1, "lat35");
    chk("t35_busy", 32'(n_busy), 32'd4);
    chk("t35_s", 32'(S), 32'(E35_S));
    chk("t35_co", 32'(CO), 32'(E35_CO));
    chk("t35_zo", 32'(ZO), 32'(E35_ZO));

    r = calc(16'h127F, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
    pin("m36", r, 16'h1280, 1'b0, 1'b0, 1'b1);
    chk("m36_mvo", 32'(r.vo), 32'h1);
    launch(16'h127F, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_done(3, 1, "lat36");
    chk("t36_s", 32'(S), 32'h1280);
    chk("t36_vo", 32'(VO), 32'h1);
    chk("t36_no", 32'(NO), 32'h1);
    chk("t36_co", 32'(CO), 32'h0);

    r = calc(16'h0000, 16'h0001, 1'b1, 1'b0, DEC_EN, 1'b1);
    pin("m37a", r, E37_S, 1'b0, 1'b0, 1'b1);
    launch(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_done(5, 1, "lat37a");
    chk("t37a_s", 32'(S), 32'(E37_S));
    chk("t37a_co", 32'(CO), 32'h0);

    r = calc(16'h0050, 16'h0070, 1'b1, 1'b0, 1'b0, 1'b0);
    pin("m37b", r, 16'h00E0, 1'b0, 1'b0, 1'b1);
    chk("m37b_mvo", 32'(r.vo), 32'h0);
    launch(16'h0050, 16'h0070, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_done(3, 1, "lat37b");
    chk("t37b_s", 32'(S[7:0]), 32'hE0);
    chk("t37b_co", 32'(CO), 32'h0);
    chk("t37b_vo", 32'(VO), 32'h0);
    chk("t37b_no", 32'(NO), 32'h1);

    r = calc(16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    pin("mx0", r, 16'h0000, 1'b1, 1'b1, 1'b0);
    chk("mx0_mvo", 32'(r.vo), 32'h1);
    for (int i = 0; i < 4; i++) begin
      launch(xa[i], xb[i], ~xad[i], xad[i], xbc[i], xw[i]);
      wait_done(xw[i] ? 5 : 3, 1, "latx");
    end

    // Reset while the third nibble is being processed.
    launch(16'h1234, 16'h1111, 1'b0, 1'b1, 1'b1, 1'b1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    chk("rm_busy", 32'(BUSY), 32'h0);
    chk("rm_done", 32'(DONE), 32'h0);
    chk("rm_s", 32'(S), 32'h0);
    chk("rm_zo", 32'(ZO), 32'h1);
    chk("rm_co", 32'(CO), 32'h0);
    @(negedge CLK); #2;
    RST = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge CLK);
      if (DONE) cnt++;
    end
    chk("rm_nodone", 32'(cnt), 32'h0);
    launch(16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_done(3, 1, "lat_rm");
    chk("rm_after_s", 32'(S), 32'h0002);

    // START held through CALC and FIN must not relaunch.
    launch(16'h0011, 16'h0022, 1'b0, 1'b1, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      START = (i <= 3);
      @(negedge CLK);
      if (DONE) cnt++;
      @(posedge CLK); #1;
    end
    START = 1'b0;
    chk("sb_done", 32'(cnt), 32'h1);
    chk("sb_s", 32'(S), 32'h0033);

    // EN low for three CALC cycles.
    launch(16'h1234, 16'h4321, 1'b0, 1'b1, 1'b1, 1'b1);
    @(posedge CLK); #1;
    EN = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
    end
    EN = 1'b1;
    wait_done(8, 5, "lat_en");
    chk("en_s", 32'(S), 32'h5555);

    @(posedge CLK); #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
